bus_pair_fifo: RTL and testbench

- Downstream capture stage for a producer that drives two 5-bit buses with opposite index direction: `o0` is `[2:-2]` and `o1` is `[-2:2]`.
- Registers each valid pair into a small synchronous FIFO and presents a single packed 10-bit word `[4:-5]` to the consumer.
- Uses valid/ready on both sides.
- Preserves the declared bit order of both buses exactly, with no reversal, so netlist-level bit slicing stays traceable through the stage.

---
 rtl/bus_pair_fifo.sv | 143 ++++++++++++++
 tb/tb_bus_pair_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_pair_fifo.sv
// rtl/bus_pair_fifo.sv - two-bus capture FIFO packing {i0, i1} into a [4:-5] word
// Optional parity storage/checking under `BUS_PAIR_FIFO_PARITY_EN.
module bus_pair_fifo #(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:-2]   i0,
   input  logic [-2:2]   i1,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [4:-5]   out_word,
   output logic [CW-1:0] count,
   output logic [CW-1:0] hwm
`ifdef BUS_PAIR_FIFO_PARITY_EN
   ,
   input  logic          chk_en,
   output logic          out_par,
   output logic          par_err
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_e;

   logic [4:-5]   mem_q [DEPTH];
   logic [4:-5]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] hwm_q, hwm_d;
   state_e        state_q, state_d;
   logic          push, pop;

`ifdef BUS_PAIR_FIFO_PARITY_EN
   logic par_q [DEPTH];
   logic par_d [DEPTH];
   logic par_err_q, par_err_d;
`endif

   // Status register tracks count exactly, so ready/valid stay a function of registered occupancy.
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_word  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign hwm       = hwm_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hwm_d    = hwm_q;
      state_d  = state_q;

      if (push) begin
         mem_d[wr_ptr_q] = {i0, i1};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (count_d > hwm_q) begin
         hwm_d = count_d;
      end

      if (count_d == '0) begin
         state_d = ST_EMPTY;
      end else if (count_d == CW'(DEPTH)) begin
         state_d = ST_FULL;
      end else begin
         state_d = ST_PARTIAL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hwm_q    <= '0;
         state_q  <= ST_EMPTY;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hwm_q    <= hwm_d;
         state_q  <= state_d;
      end
   end

`ifdef BUS_PAIR_FIFO_PARITY_EN
   assign out_par = out_valid ? par_q[rd_ptr_q] : 1'b0;
   assign par_err = par_err_q;

   always_comb begin
      par_d     = par_q;
      par_err_d = par_err_q;
      if (push) begin
         par_d[wr_ptr_q] = ^{i0, i1};
      end
      // Recompute over the head word actually leaving, against the bit stored at push.
      if (pop && chk_en && ((^mem_q[rd_ptr_q]) != par_q[rd_ptr_q])) begin
         par_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            par_q[k] <= 1'b0;
         end
         par_err_q <= 1'b0;
      end else begin
         par_q     <= par_d;
         par_err_q <= par_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_bus_pair_fifo.sv
// tb/tb_bus_pair_fifo.sv - randomized and directed bench for bus_pair_fifo against a queue model
// Parity section compiled only with `BUS_PAIR_FIFO_PARITY_EN.
module tb_bus_pair_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [2:-2]   i0 = '0;
   logic [-2:2]   i1 = '0;
   logic          in_ready, out_valid;
   logic [4:-5]   out_word;
   logic [CW-1:0] count, hwm;
`ifdef BUS_PAIR_FIFO_PARITY_EN
   logic          chk_en = 1'b0;
   logic          out_par, par_err;
`endif

   int checks = 0;
   int errors = 0;
   logic [9:0] mq [$];
   int m_hwm = 0;

   bus_pair_fifo #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .i0        (i0),
      .i1        (i1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .count     (count),
      .hwm       (hwm)
`ifdef BUS_PAIR_FIFO_PARITY_EN
      ,
      .chk_en    (chk_en),
      .out_par   (out_par),
      .par_err   (par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_count"}, 32'(count), 32'(mq.size()));
      check({tag, "_hwm"}, 32'(hwm), 32'(m_hwm));
      check({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
      check({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         check({tag, "_out_word"}, 32'(out_word), 32'(mq[0]));
      end
   endtask

   // Inputs are already applied; advance one edge and update the queue model.
   task automatic cycle(input string tag);
      bit         do_push, do_pop;
      logic [9:0] w;
      do_push = in_valid && (mq.size() != DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      w       = {i0, i1};
      @(posedge clk);
      #1;
      if (do_pop) mq.delete(0);
      if (do_push) mq.push_back(w);
      if (mq.size() > m_hwm) m_hwm = mq.size();
      check_model(tag);
   endtask

   task automatic set_rand_data();
      i0 = 5'($urandom);
      i1 = 5'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_hwm"}, 32'(hwm), 32'd0);
      check({tag, "_out_word"}, 32'(out_word), 32'h000);
   endtask

   initial begin
      logic [9:0] w;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("idle");
      check_reset_vals("idle");

      // Single push with known bit pattern.
      i0 = 5'b10110;
      i1 = 5'b01001;
      in_valid = 1'b1;
      cycle("single");
      in_valid = 1'b0;
      check("single_word", 32'(out_word), 32'h2C9);
      check("single_msb_i0", 32'(out_word[4]), 32'd1);
      check("single_msb_i1", 32'(out_word[-1]), 32'd0);
      check("single_count", 32'(count), 32'd1);

      // Fill to DEPTH, then attempt pushes while full.
      in_valid = 1'b1;
      for (int n = 0; n < DEPTH - 1; n++) begin
         i0 = 5'(n + 1);
         i1 = 5'(5'h1F - n);
         cycle("fill");
      end
      check("full_count", 32'(count), 32'(DEPTH));
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_hwm", 32'(hwm), 32'(DEPTH));
      i0 = 5'h15;
      i1 = 5'h0A;
      cycle("push_full");
      check("push_full_count", 32'(count), 32'(DEPTH));
      out_ready = 1'b1;
      cycle("push_full_pop");
      check("push_full_pop_count", 32'(count), 32'(DEPTH - 1));
      in_valid = 1'b0;
      for (int n = 0; n < DEPTH - 1; n++) cycle("drain");
      check("drain_count", 32'(count), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Asynchronous reset with three entries held.
      in_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         set_rand_data();
         cycle("pre_rst");
      end
      in_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd3);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_hwm = 0;
      check_reset_vals("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      i0 = 5'b01101;
      i1 = 5'b11000;
      w = {i0, i1};
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle("post_rst_push");
      check("post_rst_first_word", 32'(out_word), 32'(w));
      check("post_rst_slot0", 32'(dut.mem_q[0]), 32'(w));
      in_valid = 1'b0;
      cycle("post_rst_pop");

      // Hold occupancy at 2 with simultaneous push and pop across pointer wraps.
      in_valid = 1'b1;
      out_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         set_rand_data();
         cycle("steady_fill");
      end
      out_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         set_rand_data();
         cycle("steady");
         check("steady_count", 32'(count), 32'd2);
         check("steady_hwm", 32'(hwm), 32'd2);
      end
      in_valid = 1'b0;
      cycle("steady_drain");
      cycle("steady_drain");

      // Randomized traffic with varying push/pop bias.
      for (int n = 0; n < 400; n++) begin
         int bias;
         bias = (n / 50) % 3;
         in_valid  = ($urandom_range(0, 3) < ((bias == 0) ? 3 : (bias == 1) ? 1 : 2));
         out_ready = ($urandom_range(0, 3) < ((bias == 0) ? 1 : (bias == 1) ? 3 : 2));
         set_rand_data();
         cycle("rand");
      end
      in_valid = 1'b0;
      out_ready = 1'b0;

`ifdef BUS_PAIR_FIFO_PARITY_EN
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_hwm = 0;
      check("par_rst_out_par", 32'(out_par), 32'd0);
      check("par_rst_par_err", 32'(par_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i0 = 5'b10000;
      i1 = 5'b00000;
      in_valid = 1'b1;
      cycle("par_push");
      in_valid = 1'b0;
      check("par_out_par", 32'(out_par), 32'd1);
      dut.par_q[0] = 1'b0;
      chk_en = 1'b1;
      out_ready = 1'b1;
      cycle("par_pop");
      check("par_err_set", 32'(par_err), 32'd1);
      check("par_empty_out_par", 32'(out_par), 32'd0);
      chk_en = 1'b0;
      out_ready = 1'b0;
      repeat (3) cycle("par_hold");
      check("par_err_sticky", 32'(par_err), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
